ex_muldiv_stage: RTL and testbench

Parametrised execute stage for the LoongArch pipeline that adds multi-cycle multiply and divide to single-cycle ALU pass-through. It sits between the ID/EX latch and the EX/MEM latch and replaces the always-ready EX handshake with a real `ready_go` that stalls while a multiply or divide is in flight. It also exports a busy flag so ID can hold dependent instructions, and a flush input so a redirect can kill the in-flight operation.

---
 rtl/ex_muldiv_stage_pkg.sv | 48 ++++
 rtl/ex_muldiv_stage_divider.sv | 81 ++++++++
 rtl/ex_muldiv_stage.sv | 172 +++++++++++++++++
 tb/tb_ex_muldiv_stage.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_stage_pkg.sv
// ex_muldiv_stage_pkg
// Shared definitions for the execute-stage multiply/divide unit.
//   - md_op encodings (md_op_e) as seen on md_op_i
//   - FSM state encodings (state_e)
//   - XLEN_DEFAULT: default operand/result width
//   - MdOpWidth: width of the md_op field
//   - small decode helpers used by the stage
package ex_muldiv_stage_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int MdOpWidth    = 3;

  typedef enum logic [MdOpWidth-1:0] {
    MD_NONE    = 3'd0,
    MD_MUL_W   = 3'd1,
    MD_MULH_W  = 3'd2,
    MD_MULH_WU = 3'd3,
    MD_DIV_W   = 3'd4,
    MD_MOD_W   = 3'd5,
    MD_DIV_WU  = 3'd6,
    MD_MOD_WU  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic op_is_mul(input md_op_e op);
    return (op == MD_MUL_W) || (op == MD_MULH_W) || (op == MD_MULH_WU);
  endfunction

  // Signed multiply: operands are sign-extended before the wide product.
  function automatic logic op_is_signed_mul(input md_op_e op);
    return (op == MD_MUL_W) || (op == MD_MULH_W);
  endfunction

  function automatic logic op_is_signed_div(input md_op_e op);
    return (op == MD_DIV_W) || (op == MD_MOD_W);
  endfunction

  function automatic logic op_is_mod(input md_op_e op);
    return (op == MD_MOD_W) || (op == MD_MOD_WU);
  endfunction

endpackage

// File: rtl/ex_muldiv_stage_divider.sv
// md_divider
// Iterative unsigned radix-2 restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start_i              load dividend/divisor and begin (has priority)
//   kill_i               abandon the division in progress
//   dividend_i/divisor_i unsigned operands, sampled on start_i
//   done_o               high on the cycle the final bit is produced
//   quotient_o           quotient after this cycle's step (final when done_o)
//   remainder_o          remainder after this cycle's step (final when done_o)
// The divisor must be non-zero; the parent handles division by zero.
module md_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  logic            running_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [XLEN-1:0] rem_reg;
  logic [XLEN-1:0] quo_reg;
  logic [XLEN-1:0] dvs_reg;

  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;
  logic            fits;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quo_step;

  // The partial remainder is one bit wider after the shift, so the trial
  // subtraction is done at XLEN+1 bits; its top bit is the borrow.
  always_comb begin
    rem_shift = {rem_reg, quo_reg[XLEN-1]};
    diff      = rem_shift - {1'b0, dvs_reg};
    fits      = ~diff[XLEN];
    rem_step  = fits ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    quo_step  = {quo_reg[XLEN-2:0], fits};
  end

  assign done_o      = running_reg && (cnt_reg == CNT_LAST);
  assign quotient_o  = quo_step;
  assign remainder_o = rem_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      running_reg <= 1'b0;
      cnt_reg     <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      dvs_reg     <= '0;
    end else if (start_i) begin
      running_reg <= 1'b1;
      cnt_reg     <= '0;
      rem_reg     <= '0;
      quo_reg     <= dividend_i;
      dvs_reg     <= divisor_i;
    end else if (kill_i) begin
      running_reg <= 1'b0;
      cnt_reg     <= '0;
    end else if (running_reg) begin
      rem_reg <= rem_step;
      quo_reg <= quo_step;
      cnt_reg <= cnt_reg + CNT_W'(1);
      if (done_o) begin
        running_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ex_muldiv_stage.sv
// ex_muldiv_stage
// Execute stage: single-cycle ALU pass-through plus multi-cycle multiply and
// divide, with a real ready_go that stalls the ID/EX -> EX/MEM handshake.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   ex_valid_i         ID/EX latch holds a valid instruction
//   mem_allowin_i      MEM stage accepts this cycle
//   flush_i            kill the current EX instruction
//   md_op_i            0 none, 1 MUL.W, 2 MULH.W, 3 MULH.WU,
//                      4 DIV.W, 5 MOD.W, 6 DIV.WU, 7 MOD.WU
//   oper1_i, oper2_i   source operands (dividend/divisor for divides)
//   alu_result_i       ALU result used when md_op_i is 0
//   ex_allowin_o       ID/EX latch may load
//   ex_to_mem_valid_o  result valid toward MEM
//   result_o           stage result
//   busy_o             valid instruction whose result is not ready yet
module ex_muldiv_stage
  import ex_muldiv_stage_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int MUL_LAT = 2,
  parameter int MD_OP_W = MdOpWidth
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid_i,
  input  logic               mem_allowin_i,
  input  logic               flush_i,
  input  logic [MD_OP_W-1:0] md_op_i,
  input  logic [XLEN-1:0]    oper1_i,
  input  logic [XLEN-1:0]    oper2_i,
  input  logic [XLEN-1:0]    alu_result_i,
  output logic               ex_allowin_o,
  output logic               ex_to_mem_valid_o,
  output logic [XLEN-1:0]    result_o,
  output logic               busy_o
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

  state_e            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [XLEN-1:0]   result_reg;
  md_op_e            op_reg;
  logic [2*XLEN-1:0] mul_a_reg, mul_b_reg;
  logic              q_neg_reg, r_neg_reg;
  logic              ready_go;

  // Decode of the incoming instruction (only meaningful in IDLE).
  md_op_e            op_in;
  logic              a_neg, b_neg, div_by_zero, mul_signed;
  logic [XLEN-1:0]   a_abs, b_abs, zero_res;

  assign op_in       = md_op_e'(MdOpWidth'(md_op_i));
  assign a_neg       = op_is_signed_div(op_in) & oper1_i[XLEN-1];
  assign b_neg       = op_is_signed_div(op_in) & oper2_i[XLEN-1];
  assign a_abs       = a_neg ? -oper1_i : oper1_i;
  assign b_abs       = b_neg ? -oper2_i : oper2_i;
  assign div_by_zero = (oper2_i == '0);
  assign mul_signed  = op_is_signed_mul(op_in);
  // x/0 gives all-ones, x%0 gives the dividend unchanged.
  assign zero_res    = op_is_mod(op_in) ? oper1_i : '1;

  // Divider core works on magnitudes; signs are reapplied at the end.
  logic            div_start, div_kill, div_done;
  logic [XLEN-1:0] div_q, div_r;

  md_divider #(.XLEN(XLEN)) u_divider (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .kill_i      (div_kill),
    .dividend_i  (a_abs),
    .divisor_i   (b_abs),
    .done_o      (div_done),
    .quotient_o  (div_q),
    .remainder_o (div_r)
  );

  assign div_start = (state_reg == ST_IDLE) && (state_next == ST_DIV);
  assign div_kill  = flush_i | ~ex_valid_i;

  // Result formation. The low 2*XLEN bits of the product of the extended
  // operands are correct for both signed and unsigned multiplies.
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   mul_res, q_fix, r_fix, div_res;

  assign product = mul_a_reg * mul_b_reg;
  assign mul_res = (op_reg == MD_MUL_W) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  // -2^(XLEN-1) / -1 yields 2^(XLEN-1) as a magnitude, which negates back to
  // itself, so the overflow case needs no extra handling.
  assign q_fix   = q_neg_reg ? -div_q : div_q;
  assign r_fix   = r_neg_reg ? -div_r : div_r;
  assign div_res = op_is_mod(op_reg) ? r_fix : q_fix;

  always_comb begin
    state_next = state_reg;
    ready_go   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (op_in == MD_NONE) begin
          ready_go = 1'b1;
        end else if (op_is_mul(op_in)) begin
          state_next = ST_MUL;
        end else if (div_by_zero) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_DIV;
        end
      end
      ST_MUL: begin
        if (cnt_reg == CNT_LAST) begin
          state_next = ST_DONE;
        end
      end
      ST_DIV: begin
        if (div_done) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        ready_go = 1'b1;
        if (mem_allowin_i) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // A flush or a vanished instruction always returns to IDLE, overriding
    // any transition above (including DONE holding under back-pressure).
    if (flush_i || !ex_valid_i) begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      result_reg <= '0;
      op_reg     <= MD_NONE;
      mul_a_reg  <= '0;
      mul_b_reg  <= '0;
      q_neg_reg  <= 1'b0;
      r_neg_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= ((state_reg == ST_MUL) && (state_next == ST_MUL)) ? cnt_reg + CNT_W'(1) : '0;
      if ((state_reg == ST_IDLE) && (state_next != ST_IDLE)) begin
        op_reg    <= op_in;
        mul_a_reg <= {{XLEN{mul_signed & oper1_i[XLEN-1]}}, oper1_i};
        mul_b_reg <= {{XLEN{mul_signed & oper2_i[XLEN-1]}}, oper2_i};
        q_neg_reg <= a_neg ^ b_neg;
        r_neg_reg <= a_neg;
      end
      if ((state_reg == ST_IDLE) && (state_next == ST_DONE)) begin
        result_reg <= zero_res;
      end else if ((state_reg == ST_MUL) && (state_next == ST_DONE)) begin
        result_reg <= mul_res;
      end else if ((state_reg == ST_DIV) && (state_next == ST_DONE)) begin
        result_reg <= div_res;
      end
    end
  end

  assign ex_allowin_o      = ~ex_valid_i | (ready_go & mem_allowin_i);
  assign ex_to_mem_valid_o = ex_valid_i & ready_go & ~flush_i;
  assign busy_o            = ex_valid_i & ~ready_go;
  assign result_o          = ((state_reg == ST_IDLE) && (op_in == MD_NONE)) ? alu_result_i : result_reg;

endmodule

// File: tb/tb_ex_muldiv_stage.sv
module tb_ex_muldiv_stage;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 2;
  localparam int MD_OP_W = 3;
  localparam int MAX_AGE = 200;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_valid;
  logic            mem_allowin;
  logic            flush;
  logic [2:0]      md_op;
  logic [XLEN-1:0] oper1, oper2, alu_result;
  logic            ex_allowin, ex_to_mem_valid, busy;
  logic [XLEN-1:0] result;

  int n_checks = 0;
  int n_errors = 0;

  // Expectations presented to the compare process for the current cycle.
  logic            chk_en = 1'b0;
  logic            exp_valid, exp_busy, exp_allowin, exp_chk_res;
  logic [XLEN-1:0] exp_result;

  always #5 clk = ~clk;

  ex_muldiv_stage #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .MD_OP_W(MD_OP_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .ex_valid_i        (ex_valid),
    .mem_allowin_i     (mem_allowin),
    .flush_i           (flush),
    .md_op_i           (md_op),
    .oper1_i           (oper1),
    .oper2_i           (oper2),
    .alu_result_i      (alu_result),
    .ex_allowin_o      (ex_allowin),
    .ex_to_mem_valid_o (ex_to_mem_valid),
    .result_o          (result),
    .busy_o            (busy)
  );

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%08h expected=%08h", name, $time, act, exp);
    end
  endtask

  // Single compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check_bit("ex_to_mem_valid", ex_to_mem_valid, exp_valid);
      check_bit("busy", busy, exp_busy);
      check_bit("ex_allowin", ex_allowin, exp_allowin);
      if (exp_chk_res) begin
        check_word("result", result, exp_result);
      end
    end
  end

  // Reference model: plain 64-bit arithmetic on the architectural operation.
  function automatic logic [XLEN-1:0] model_res(input int op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b, input logic [XLEN-1:0] alu);
    longint sa, sb, r;
    logic [63:0] ua, ub, u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      0: return alu;
      1: begin r = sa * sb; return r[31:0]; end
      2: begin r = sa * sb; return r[63:32]; end
      3: begin u = ua * ub; return u[63:32]; end
      4: begin if (b == 0) return '1; r = sa / sb; return r[31:0]; end
      5: begin if (b == 0) return a;  r = sa % sb; return r[31:0]; end
      6: begin if (b == 0) return '1; u = ua / ub; return u[31:0]; end
      default: begin if (b == 0) return a; u = ua % ub; return u[31:0]; end
    endcase
  endfunction

  function automatic int model_lat(input int op, input logic [XLEN-1:0] b);
    if (op == 0) return 0;
    if (op <= 3) return MUL_LAT + 1;
    if (b == 0) return 1;
    return XLEN + 1;
  endfunction

  task automatic set_exp(input logic v, input logic bz, input logic al, input logic cr, input logic [XLEN-1:0] res);
    exp_valid   = v;
    exp_busy    = bz;
    exp_allowin = al;
    exp_chk_res = cr;
    exp_result  = res;
    chk_en      = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n, input logic chk_res);
    ex_valid    = 1'b0;
    flush       = 1'b0;
    mem_allowin = 1'b1;
    md_op       = 3'd1;
    set_exp(1'b0, 1'b0, 1'b1, chk_res, '0);
    repeat (n) tick();
  endtask

  // Present one instruction and follow it until it is handed to MEM.
  // stall = number of valid cycles during which MEM refuses.
  task automatic do_op(input int op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] alu, input int stall);
    int lat, age, st;
    logic [XLEN-1:0] exp;
    logic done;
    exp = model_res(op, a, b, alu);
    lat = model_lat(op, b);
    ex_valid = 1'b1; flush = 1'b0; md_op = 3'(op);
    oper1 = a; oper2 = b; alu_result = alu;
    st = stall;
    mem_allowin = (st == 0);
    done = 1'b0;
    age = 0;
    while (!done && age < MAX_AGE) begin
      set_exp(age >= lat, age < lat, (age >= lat) && mem_allowin, age >= lat, exp);
      tick();
      // Operands are latched at cycle 0; later changes must not matter.
      if (age == 0 && op != 0) begin
        oper1 = $urandom;
        oper2 = $urandom;
      end
      if (age >= lat) begin
        if (mem_allowin) done = 1'b1;
        else begin
          st--;
          if (st <= 0) mem_allowin = 1'b1;
        end
      end
      age++;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout op=%0d got=no_handoff expected=handoff_by_cycle_%0d", op, lat + stall);
    end
    $display("txn op=%0d a=%08h b=%08h expect=%08h latency=%0d stall=%0d", op, a, b, exp, lat, stall);
  endtask

  // Present an instruction, then kill it at kill_age by flush or by dropping
  // ex_valid. MEM refuses until the kill cycle so DONE is held if reached.
  task automatic do_kill(input int op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input int kill_age, input logic use_flush);
    int lat;
    logic [XLEN-1:0] exp;
    exp = model_res(op, a, b, 32'h0);
    lat = model_lat(op, b);
    ex_valid = 1'b1; flush = 1'b0; md_op = 3'(op);
    oper1 = a; oper2 = b; alu_result = 32'h0;
    mem_allowin = 1'b0;
    for (int age = 0; age < kill_age; age++) begin
      set_exp(age >= lat, age < lat, 1'b0, age >= lat, exp);
      tick();
      if (age == 0 && op != 0) begin
        oper1 = $urandom;
        oper2 = $urandom;
      end
    end
    mem_allowin = 1'b1;
    if (use_flush) begin
      flush = 1'b1;
      set_exp(1'b0, kill_age < lat, kill_age >= lat, 1'b0, '0);
    end else begin
      ex_valid = 1'b0;
      set_exp(1'b0, 1'b0, 1'b1, 1'b0, '0);
    end
    tick();
    flush = 1'b0;
    ex_valid = 1'b0;
    set_exp(1'b0, 1'b0, 1'b1, 1'b0, '0);
    tick();
    $display("txn op=%0d a=%08h b=%08h killed_at=%0d by=%s", op, a, b, kill_age, use_flush ? "flush" : "valid_drop");
  endtask

  // Reset in the middle of a multiply: all outputs back to reset values.
  task automatic do_reset_mid_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    ex_valid = 1'b1; flush = 1'b0; md_op = 3'd1;
    oper1 = a; oper2 = b; mem_allowin = 1'b1;
    set_exp(1'b0, 1'b1, 1'b0, 1'b0, '0);
    tick();
    rst = 1'b1;
    set_exp(1'b0, 1'b1, 1'b0, 1'b0, '0);
    tick();
    rst = 1'b0;
    ex_valid = 1'b0;
    set_exp(1'b0, 1'b0, 1'b1, 1'b1, '0);
    tick();
    $display("txn reset_mid_mul a=%08h b=%08h", a, b);
  endtask

  function automatic logic [XLEN-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; ex_valid = 1'b0; mem_allowin = 1'b1; flush = 1'b0;
    md_op = 3'd1; oper1 = '0; oper2 = '0; alu_result = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(2, 1'b1);

    // Hand-computed values that pin the reference model.
    check_word("model_mulh",   model_res(2, 32'hFFFF_FFFF, 32'h2, 0), 32'hFFFF_FFFF);
    check_word("model_mulhu",  model_res(3, 32'hFFFF_FFFF, 32'h2, 0), 32'h0000_0001);
    check_word("model_div",    model_res(4, 32'hFFFF_FFF9, 32'h2, 0), 32'hFFFF_FFFD);
    check_word("model_mod",    model_res(5, 32'hFFFF_FFF9, 32'h2, 0), 32'hFFFF_FFFF);
    check_word("model_div_ovf", model_res(4, 32'h8000_0000, 32'hFFFF_FFFF, 0), 32'h8000_0000);
    check_word("model_divu_z", model_res(6, 32'h5, 32'h0, 0), 32'hFFFF_FFFF);
    check_word("model_modu_z", model_res(7, 32'h5, 32'h0, 0), 32'h0000_0005);
    check_word("model_mul",    model_res(1, 32'h3, 32'h4, 0), 32'h0000_000C);

    // ALU pass-through, back to back.
    do_op(0, 32'h0, 32'h0, 32'h0000_1234, 0);
    do_op(0, 32'h0, 32'h0, 32'hDEAD_BEEF, 0);
    do_op(0, 32'h0, 32'h0, 32'h0000_0042, 0);

    // Multiplies.
    do_op(2, 32'hFFFF_FFFF, 32'h2, 32'h0, 0);
    do_op(3, 32'hFFFF_FFFF, 32'h2, 32'h0, 0);
    do_op(1, 32'h3, 32'h4, 32'h0, 0);

    // Divides, including signed overflow.
    do_op(4, 32'hFFFF_FFF9, 32'h2, 32'h0, 0);
    do_op(5, 32'hFFFF_FFF9, 32'h2, 32'h0, 0);
    do_op(4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
    do_op(5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);

    // Divide by zero.
    do_op(6, 32'h5, 32'h0, 32'h0, 0);
    do_op(7, 32'h5, 32'h0, 32'h0, 0);
    do_op(5, 32'hFFFF_FFF9, 32'h0, 32'h0, 0);

    // Back-pressure on a completed divide, then the next op starts.
    do_op(4, 32'd100, 32'd7, 32'h0, 4);
    do_op(1, 32'h3, 32'h4, 32'h0, 0);

    // Flush at DIV cycle 10, then a multiply must see full latency.
    do_kill(4, 32'd1000, 32'd3, 10, 1'b1);
    do_op(1, 32'h3, 32'h4, 32'h0, 0);
    // Upstream drop during MUL.
    do_kill(1, 32'h7, 32'h9, 1, 1'b0);
    do_op(2, 32'h8000_0000, 32'h8000_0000, 32'h0, 0);
    // Flush while DONE is held by back-pressure.
    do_kill(6, 32'd77, 32'd5, 35, 1'b1);
    do_op(7, 32'd77, 32'd5, 32'h0, 0);

    // Reset during a multiply (previous result non-zero).
    do_op(1, 32'h3, 32'h4, 32'h0, 0);
    do_reset_mid_mul(32'h1234_5678, 32'h9);
    do_op(1, 32'h3, 32'h4, 32'h0, 0);

    // Randomised traffic.
    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 7);
      if (i % 10 == 5) begin
        do_kill(op, pick(), pick(), $urandom_range(0, 12), 1'($urandom_range(0, 1)));
      end else begin
        do_op(op, pick(), pick(), $urandom,
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end
      if ($urandom_range(0, 4) == 0) begin
        idle_cycles($urandom_range(1, 2), 1'b0);
      end
    end

    idle_cycles(2, 1'b0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
